// File: rtl/clock_time_core.sv
// Time-of-day core: binary sec/min/hr with a one-second prescaler, plus a
// two-button setting interface (mode cycle, field increment).
module clock_time_core #(
  parameter int unsigned CLKS_PER_SEC = 10_000_000
) (
  input  logic        clock,
  input  logic        resetb,
  input  logic        counter_trigger,
  input  logic        increment_trigger,
  output logic [17:0] led_output,
  output logic        mode_led_output
);

  localparam int unsigned PS_W = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_SEC = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_HR  = 2'd3
  } mode_t;

  mode_t mode, mode_nxt;

  logic [PS_W-1:0] prescaler, prescaler_nxt;
  logic [5:0]      sec_q, sec_nxt;
  logic [5:0]      min_q, min_nxt;
  logic [5:0]      hr_q, hr_nxt;
  logic            mode_led_q;
  logic            tick;

  // Per trigger: bit 0 = s1, bit 1 = s2, bit 2 = s3 (edge-detect delay)
  logic [2:0] cnt_sync, inc_sync;
  logic       cnt_pulse, inc_pulse;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt_sync <= '0;
      inc_sync <= '0;
    end else begin
      cnt_sync <= {cnt_sync[1:0], counter_trigger};
      inc_sync <= {inc_sync[1:0], increment_trigger};
    end
  end

  assign cnt_pulse = cnt_sync[1] & ~cnt_sync[2];
  assign inc_pulse = inc_sync[1] & ~inc_sync[2];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      mode       <= MODE_RUN;
      mode_led_q <= 1'b0;
    end else begin
      mode       <= mode_nxt;
      mode_led_q <= (mode_nxt != MODE_RUN);
    end
  end

  always_comb begin
    mode_nxt = mode;
    if (cnt_pulse) begin
      unique case (mode)
        MODE_RUN:     mode_nxt = MODE_SET_SEC;
        MODE_SET_SEC: mode_nxt = MODE_SET_MIN;
        MODE_SET_MIN: mode_nxt = MODE_SET_HR;
        MODE_SET_HR:  mode_nxt = MODE_RUN;
      endcase
    end
  end

  always_comb begin
    prescaler_nxt = prescaler;
    sec_nxt       = sec_q;
    min_nxt       = min_q;
    hr_nxt        = hr_q;
    tick          = 1'b0;
    if (mode == MODE_RUN) begin
      if (prescaler == PS_LAST) begin
        prescaler_nxt = '0;
        tick          = 1'b1;
      end else begin
        prescaler_nxt = prescaler + PS_W'(1);
      end
      if (tick) begin
        if (sec_q == 6'd59) begin
          sec_nxt = '0;
          if (min_q == 6'd59) begin
            min_nxt = '0;
            hr_nxt  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
          end else begin
            min_nxt = min_q + 6'd1;
          end
        end else begin
          sec_nxt = sec_q + 6'd1;
        end
      end
    end else begin
      // Setting modes freeze time; fields wrap independently with no carry
      prescaler_nxt = '0;
      if (inc_pulse) begin
        unique case (mode)
          MODE_SET_SEC: sec_nxt = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
          MODE_SET_MIN: min_nxt = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          MODE_SET_HR:  hr_nxt  = (hr_q == 6'd23) ? 6'd0 : hr_q + 6'd1;
          MODE_RUN:     ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      prescaler <= '0;
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
    end else begin
      prescaler <= prescaler_nxt;
      sec_q     <= sec_nxt;
      min_q     <= min_nxt;
      hr_q      <= hr_nxt;
    end
  end

  assign led_output      = {hr_q, min_q, sec_q};
  assign mode_led_output = mode_led_q;

endmodule

// File: tb/tb_clock_time_core.sv
// Scoreboarded bench for clock_time_core: a seconds-of-day reference model
// predicts outputs each edge; a negedge monitor compares against the DUT.
module tb_clock_time_core;

  localparam int unsigned N = 4;

  logic        clock = 1'b0;
  logic        resetb;
  logic        counter_trigger;
  logic        increment_trigger;
  logic [17:0] led_output;
  logic        mode_led_output;

  always #5 clock = ~clock;

  clock_time_core #(.CLKS_PER_SEC(N)) dut (
    .clock            (clock),
    .resetb           (resetb),
    .counter_trigger  (counter_trigger),
    .increment_trigger(increment_trigger),
    .led_output       (led_output),
    .mode_led_output  (mode_led_output)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time held as seconds since midnight
  int          m_tod, m_mode, m_ps;
  bit [2:0]    ch, ih;   // input samples from 1, 2, 3 edges ago
  logic [18:0] sbq[$];
  logic [18:0] mon_exp;

  function automatic logic [18:0] model_out();
    int h, mi, s;
    h  = m_tod / 3600;
    mi = (m_tod / 60) % 60;
    s  = m_tod % 60;
    return {6'(h), 6'(mi), 6'(s), (m_mode != 0)};
  endfunction

  task automatic model_reset();
    m_tod = 0; m_mode = 0; m_ps = 0; ch = '0; ih = '0;
  endtask

  task automatic bump_field(input int field);
    int s, mi, h;
    s  = m_tod % 60;
    mi = (m_tod / 60) % 60;
    h  = m_tod / 3600;
    case (field)
      1: s  = (s + 1) % 60;
      2: mi = (mi + 1) % 60;
      3: h  = (h + 1) % 24;
      default: ;
    endcase
    m_tod = h * 3600 + mi * 60 + s;
  endtask

  always @(negedge resetb) begin
    model_reset();
    sbq.delete();
  end

  always @(posedge clock) begin
    bit cp, ip;
    if (!resetb) begin
      model_reset();
    end else begin
      cp = ch[1] && !ch[2];
      ip = ih[1] && !ih[2];
      ch = {ch[1:0], counter_trigger};
      ih = {ih[1:0], increment_trigger};
      if (m_mode == 0) begin
        if (m_ps == N - 1) begin
          m_ps  = 0;
          m_tod = (m_tod + 1) % 86400;
        end else begin
          m_ps++;
        end
      end else begin
        m_ps = 0;
        if (ip) bump_field(m_mode);
      end
      if (cp) m_mode = (m_mode + 1) % 4;
    end
    sbq.push_back(model_out());
  end

  always @(negedge clock) begin
    if (sbq.size() != 0) begin
      mon_exp = sbq.pop_front();
      check("scoreboard", {13'd0, led_output, mode_led_output}, {13'd0, mon_exp});
    end
  end

  // Called at a negedge; returns at a negedge
  task automatic press(input bit inc);
    if (inc) increment_trigger = 1'b1; else counter_trigger = 1'b1;
    repeat (2) @(negedge clock);
    increment_trigger = 1'b0;
    counter_trigger   = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 resetb = 1'b0;
    counter_trigger   = 1'b0;
    increment_trigger = 1'b0;
    #1;
    check("reset_led", {14'd0, led_output}, 32'd0);
    check("reset_mode_led", {31'd0, mode_led_output}, 32'd0);
    @(negedge clock);
    resetb = 1'b1;
  endtask

  initial begin
    int c_left, i_left;
    resetb = 1'b0;
    counter_trigger = 1'b0;
    increment_trigger = 1'b0;
    repeat (3) @(negedge clock);
    check("por_led", {14'd0, led_output}, 32'd0);
    check("por_mode_led", {31'd0, mode_led_output}, 32'd0);
    resetb = 1'b1;

    // Free run
    repeat (3) @(negedge clock);
    check("pre_first_tick", {14'd0, led_output}, 32'd0);
    @(negedge clock);
    check("first_tick", {14'd0, led_output}, 32'd1);
    repeat (236) @(negedge clock);
    check("one_minute", {14'd0, led_output}, 32'd64);

    // Mode cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(1'b0);
      check("mode_cycle_led", {31'd0, mode_led_output}, (i < 3) ? 32'd1 : 32'd0);
    end
    repeat (2 * N) @(negedge clock);

    // Bring-up set sequence
    do_reset();
    press(1'b0); press(1'b1);
    press(1'b0); press(1'b1);
    press(1'b0); press(1'b1);
    press(1'b0);
    check("bringup_set", {14'd0, led_output}, 32'd4161);
    press(1'b1);
    check("inc_in_run", {20'd0, led_output[17:6]}, 32'd65);

    // Wrap with no carry
    do_reset();
    press(1'b0);
    repeat (59) press(1'b1);
    check("sec_59", {14'd0, led_output}, 32'd59);
    press(1'b1);
    check("sec_wrap", {14'd0, led_output}, 32'd0);
    press(1'b0); press(1'b0);
    repeat (23) press(1'b1);
    check("hr_23", {26'd0, led_output[17:12]}, 32'd23);
    press(1'b1);
    check("hr_wrap", {14'd0, led_output}, 32'd0);

    // Rollover
    do_reset();
    press(1'b0); repeat (59) press(1'b1);
    press(1'b0); repeat (59) press(1'b1);
    press(1'b0); repeat (23) press(1'b1);
    check("set_235959", {14'd0, led_output}, (32'd23 << 12) | (32'd59 << 6) | 32'd59);
    press(1'b0);
    repeat (2) @(negedge clock);
    check("pre_rollover", {14'd0, led_output}, (32'd23 << 12) | (32'd59 << 6) | 32'd59);
    @(negedge clock);
    check("rollover", {14'd0, led_output}, 32'd0);

    // Simultaneous triggers in mode 1
    do_reset();
    press(1'b0);
    counter_trigger   = 1'b1;
    increment_trigger = 1'b1;
    repeat (2) @(negedge clock);
    check("simul_before", {14'd0, led_output}, 32'd0);
    @(negedge clock);
    check("simul_sec", {14'd0, led_output}, 32'd1);
    check("simul_mode_led", {31'd0, mode_led_output}, 32'd1);
    counter_trigger   = 1'b0;
    increment_trigger = 1'b0;
    repeat (2) @(negedge clock);
    press(1'b1);
    check("simul_in_mode2", {14'd0, led_output}, 32'd65);

    // Mid-operation reset in mode 2 (zero checks inside do_reset)
    do_reset();

    // Trigger held high across reset release
    @(negedge clock);
    #2 resetb = 1'b0;
    counter_trigger = 1'b1;
    @(negedge clock);
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    check("held_across_reset", {31'd0, mode_led_output}, 32'd1);
    counter_trigger = 1'b0;
    repeat (2) @(negedge clock);

    // Randomized button activity, each level held 2..6 cycles
    do_reset();
    c_left = $urandom_range(2, 6);
    i_left = $urandom_range(2, 6);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      if (--c_left == 0) begin
        counter_trigger = ~counter_trigger;
        c_left = $urandom_range(2, 6);
      end
      if (--i_left == 0) begin
        increment_trigger = ~increment_trigger;
        i_left = $urandom_range(2, 6);
      end
      if (cyc == 1500) do_reset();
    end
    counter_trigger   = 1'b0;
    increment_trigger = 1'b0;
    repeat (8) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
